// File: rtl/mc_main_control.sv
// Multi-cycle MIPS main control FSM.
// Sequences fetch/decode/execute/mem/writeback and counts retired instructions.
module mc_main_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             branch_ne,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    RWB     = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    ADDI_EX = 4'd10,
    ANDI_EX = 4'd11,
    IMM_WB  = 4'd12,
    RST     = 4'd15
  } st_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  st_t  cur;
  st_t  nxt;
  logic retire;

  assign state = cur;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur         <= RST;
      retired_cnt <= '0;
    end else begin
      cur <= nxt;
      if (retire)
        retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    nxt           = FETCH;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;
    case (cur)
      RST: nxt = FETCH;
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        nxt       = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_R:          nxt = EXEC;
          OP_LW, OP_SW:  nxt = MEMADR;
          OP_BEQ, OP_BNE: nxt = BRANCH;
          OP_J:          nxt = JUMP;
          OP_ADDI:       nxt = ADDI_EX;
          OP_ANDI:       nxt = ANDI_EX;
          default: begin
            nxt        = FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_SW)
          nxt = MEMWR;
        else if (opcode == OP_LW)
          nxt = MEMRD;
        else
          nxt = FETCH;
      end
      ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = IMM_WB;
      end
      ANDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
        nxt       = IMM_WB;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        nxt      = mem_ready ? MEMWB : MEMRD;
      end
      MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        nxt       = mem_ready ? FETCH : MEMWR;
        retire    = mem_ready;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        nxt       = RWB;
      end
      RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      IMM_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        branch_ne     = (opcode == OP_BNE);
        retire        = 1'b1;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retire    = 1'b1;
      end
      // 13/14 never entered; fall back to FETCH quietly
      default: nxt = FETCH;
    endcase
  end

endmodule

// File: doc/mc_main_control.md
Name: mc_main_control

Overview:
- Multi-cycle MIPS main control unit, built as a Moore FSM with a small amount of Mealy gating on `mem_ready`.
- Decodes the 6-bit opcode held in the instruction register.
- Sequences fetch, decode, execute, memory and writeback steps.
- Drives every datapath enable, and produces the 2-bit `alu_op` consumed by the ALU control decoder.
- Sits between the instruction register and the multi-cycle datapath. It also counts retired instructions.

Parameters:
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- opcode  in  6  instruction[31:26] from the instruction register.
- mem_ready  in  1  memory has completed the current read/write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  conditional PC load (branch).
- branch_ne  out  1  branch condition inverted (bne).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  writeback data select: 1 = MDR.
- reg_dst  out  1  destination select: 1 = rd, 0 = rt.
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = shifted immediate.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct, 11 = and (andi).
- pc_source  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- illegal_op  out  1  unrecognised opcode in DECODE.
- state  out  4  current state, for debug.
- retired_cnt  out  CNT_W  instructions completed, wraps modulo 2^CNT_W.

Behaviour:
- Reset: rst_n low at a rising edge sets state = RST (4'hF) and retired_cnt = 0.
  - In RST every output is 0.
  - RST moves to FETCH on the next edge while rst_n is high.
  - Reset is honoured from any state, aborting the instruction in progress. No write-back occurs once the edge is taken.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDI_EX 10, ANDI_EX 11, IMM_WB 12, RST 15. Codes 13 and 14 are unreachable and recover to FETCH with all outputs 0.
- Outputs per state; any output not listed is 0:
  - FETCH: mem_read=1, alu_src_b=01, alu_op=00, pc_source=00, ir_write=mem_ready, pc_write=mem_ready. Stays in FETCH while mem_ready=0.
  - DECODE: alu_src_b=11, alu_op=00.
  - MEMADR, ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00.
  - ANDI_EX: alu_src_a=1, alu_src_b=10, alu_op=11.
  - MEMRD: mem_read=1, iord=1. Holds until mem_ready=1.
  - MEMWR: mem_write=1, iord=1. Holds until mem_ready=1.
  - MEMWB: reg_write=1, mem_to_reg=1.
  - EXEC: alu_src_a=1, alu_op=10.
  - RWB: reg_write=1, reg_dst=1.
  - IMM_WB: reg_write=1.
  - BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01, branch_ne=(opcode==6'h05).
  - JUMP: pc_write=1, pc_source=10.
- DECODE dispatch on opcode:
  - 6'h00 → EXEC
  - 6'h23 or 6'h2B → MEMADR
  - 6'h04 or 6'h05 → BRANCH
  - 6'h02 → JUMP
  - 6'h08 → ADDI_EX
  - 6'h0C → ANDI_EX
  - any other opcode → FETCH, with illegal_op=1 during that DECODE cycle only.
- Other transitions:
  - MEMADR → MEMRD if opcode is lw (6'h23), → MEMWR if opcode is sw (6'h2B).
  - MEMRD → MEMWB.
  - EXEC → RWB.
  - ADDI_EX and ANDI_EX → IMM_WB.
  - MEMWB, RWB, IMM_WB, BRANCH, JUMP → FETCH.
  - MEMWR → FETCH when mem_ready=1.
- Retirement: retired_cnt increments by 1 on each transition into FETCH from MEMWB, MEMWR, RWB, IMM_WB, BRANCH or JUMP.
  - Illegal opcodes and reset do not increment it.
  - The count wraps from all-ones to 0.
- Cycle counts with mem_ready always 1:
  - R-type, addi, andi, sw: 4 cycles.
  - lw: 5 cycles.
  - beq, bne, j: 3 cycles.
- opcode must be stable from DECODE until return to FETCH; the instruction register is written only in FETCH.

Test Plan:
- Reset held 2 cycles, then released → state=15 with all outputs 0, then FETCH with mem_read=1 and alu_src_b=01; retired_cnt=0.
- opcode=6'h23 with mem_ready high only on the 3rd FETCH cycle and the 2nd MEMRD cycle → state sequence 0,0,0,1,2,3,3,4,0; ir_write and pc_write pulse only on the final FETCH cycle; MEMWB shows reg_write=1, mem_to_reg=1; retired_cnt=1.
- opcode=6'h00 → states 0,1,6,7; EXEC shows alu_op=10; RWB shows reg_dst=1, reg_write=1.
- opcode=6'h05, then 6'h04 → BRANCH shows branch_ne=1, then 0; alu_op=01, pc_source=01, pc_write_cond=1 in both.
- opcode=6'h3F → illegal_op=1 for exactly the DECODE cycle, next state FETCH, retired_cnt unchanged.
- sw stalled in MEMWR (mem_ready=0), rst_n low one cycle → state=15 and mem_write=0 next cycle.
- CNT_W=2, five j instructions back to back → retired_cnt reads 1,2,3,0,1.
